// File: rtl/store_commit_buffer_pkg.sv
// lsu_pkg: shared store-buffer types and the byte-lane helper used for drain and forwarding.
package lsu_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_SH = 3'b001;
    localparam logic [2:0] FUNCT3_SW = 3'b010;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [2:0]        funct3;
    } sb_entry_t;
    typedef enum logic {IDLE, SEND} sb_state_t;
    typedef struct packed {
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
        logic              ok;
    } lane_t;
    function automatic lane_t store_lane(input logic [2:0] funct3, input logic [1:0] addr,
                                         input logic [DATA_W-1:0] data);
        lane_t r;
        r.ok = (funct3 == FUNCT3_SB) || (funct3 == FUNCT3_SH && !addr[0]) ||
               (funct3 == FUNCT3_SW && addr == 2'b00);
        r.wstrb = !r.ok ? '0 : funct3 == FUNCT3_SB ? 4'b0001 << addr :
                  funct3 == FUNCT3_SH ? 4'b0011 << addr : 4'b1111;
        r.wdata = funct3 == FUNCT3_SB ? {4{data[7:0]}} : funct3 == FUNCT3_SH ? {2{data[15:0]}} : data;
        return r;
    endfunction
endpackage

// File: rtl/store_commit_buffer_lane_gen.sv
// store_lane_gen: combinational byte strobe, lane replication and alignment check for one store.
module store_lane_gen
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              ok_o
);
    lane_t lane;
    assign lane = store_lane(funct3_i, addr_i, data_i);
    assign wstrb_o = lane.wstrb;
    assign wdata_o = lane.wdata;
    assign ok_o = lane.ok;
endmodule

// File: rtl/store_commit_buffer.sv
// store_commit_buffer: in-order post-commit store queue draining to data memory over req/ack.
// STORE_COMMIT_FWD_EN adds the youngest-match store-to-load forwarding port.
module store_commit_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_we,
    input  logic [ADDR_W-1:0] commit_addr,
    input  logic [DATA_W-1:0] commit_data,
    input  logic [2:0]        commit_funct3,
    output logic              sb_full,
    output logic              sb_empty,
    output logic              overflow_err,
    output logic              misalign_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
`ifdef STORE_COMMIT_FWD_EN
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
`endif
    input  logic              mem_ack
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    sb_entry_t buf_q [DEPTH];
    sb_entry_t commit_e, ent_a, ent_b;
    logic [PW-1:0] head_q, tail_q, head_nx;
    logic [CW-1:0] count_q;
    sb_state_t state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, a_wdata, b_wdata;
    logic [STRB_W-1:0] mem_wstrb_q, a_wstrb, b_wstrb;
    logic overflow_q, a_ok, b_ok, full, drop, adv, vld, load, push;
    assign commit_e = '{addr: commit_addr, data: commit_data, funct3: commit_funct3};
    assign head_nx = head_q + PW'(1);
    // A: current head (or bypassed commit); B: entry that follows once the head leaves.
    always_comb begin
        ent_a = count_q != '0 ? buf_q[head_q] : commit_e;
        ent_b = count_q > CW'(1) ? buf_q[head_nx] : commit_e;
        full = count_q == CW'(DEPTH);
        drop = state_q == IDLE && count_q != '0 && !a_ok;
        adv = state_q == SEND ? mem_ack : drop;
        vld = commit_we || (adv ? count_q > CW'(1) : count_q != '0);
    end
    store_lane_gen u_lane_a (.funct3_i(ent_a.funct3), .addr_i(ent_a.addr[1:0]), .data_i(ent_a.data),
                             .wstrb_o(a_wstrb), .wdata_o(a_wdata), .ok_o(a_ok));
    store_lane_gen u_lane_b (.funct3_i(ent_b.funct3), .addr_i(ent_b.addr[1:0]), .data_i(ent_b.data),
                             .wstrb_o(b_wstrb), .wdata_o(b_wdata), .ok_o(b_ok));
    always_comb begin
        load = vld && (adv ? b_ok : a_ok) && (state_q == IDLE || mem_ack);
        push = commit_we && (!full || adv);
        state_d = load || (state_q == SEND && !mem_ack) ? SEND : IDLE;
    end
    always_ff @(posedge clk) begin
        if (push) buf_q[tail_q] <= commit_e;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            state_q <= IDLE;
            mem_addr_q <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (adv) head_q <= head_nx;
            count_q <= count_q + CW'(push) - CW'(adv);
            state_q <= state_d;
            if (load) begin
                mem_addr_q <= {(adv ? ent_b.addr[ADDR_W-1:2] : ent_a.addr[ADDR_W-1:2]), 2'b00};
                mem_wdata_q <= adv ? b_wdata : a_wdata;
                mem_wstrb_q <= adv ? b_wstrb : a_wstrb;
            end
            if (commit_we && full && !adv) overflow_q <= 1'b1;
        end
    end
    assign sb_full = full;
    assign sb_empty = count_q == '0;
    assign overflow_err = overflow_q;
    assign misalign_err = drop;
    assign mem_req = state_q == SEND;
    assign mem_addr = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
`ifdef STORE_COMMIT_FWD_EN
    logic [STRB_W-1:0] e_strb [DEPTH];
    logic [DATA_W-1:0] e_data [DEPTH];
    logic              e_ok   [DEPTH];
    for (genvar g = 0; g < DEPTH; g++) begin : g_fwd
        store_lane_gen u_lane (.funct3_i(buf_q[g].funct3), .addr_i(buf_q[g].addr[1:0]),
                               .data_i(buf_q[g].data), .wstrb_o(e_strb[g]), .wdata_o(e_data[g]),
                               .ok_o(e_ok[g]));
    end
    // Walk oldest to youngest so the youngest word match wins; only full-word cover hits.
    always_comb begin
        logic [PW-1:0] idx;
        ld_hit = 1'b0;
        ld_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q && buf_q[idx].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]) begin
                ld_hit = ld_addr[1:0] == 2'b00 && e_ok[idx] && e_strb[idx] == 4'b1111;
                ld_data = e_data[idx];
            end
        end
    end
`endif
endmodule
